// File: rtl/up_bus_arbiter.sv
// up_bus_arbiter: two-master to one-slave register bus arbiter.
// Each master has a one-entry pending buffer. Full buffers are granted
// round-robin, and one access at a time runs on the shared slave bus.
// A write takes ISSUE then IDLE. A read waits RD_LAT cycles in RD_WAIT,
// then returns its data to the master that was granted.
// Ports:
//   up_clk, up_rst_n        clock, async active-low reset
//   mN_addr/wr_data/wr/rd   master N request (N = 0, 1)
//   mN_rd_data/rd_valid     read return to master N
//   mN_busy, mN_ovf         request pending/in flight, sticky drop flag
//   s_addr/wr_data/wr/rd    shared slave bus
//   s_rd_data               slave read data
module up_bus_arbiter #(
  parameter int unsigned RD_LAT = 2
) (
  input  logic        up_clk,
  input  logic        up_rst_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wr_data,
  input  logic        m0_wr,
  input  logic        m0_rd,
  output logic [31:0] m0_rd_data,
  output logic        m0_rd_valid,
  output logic        m0_busy,
  output logic        m0_ovf,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wr_data,
  input  logic        m1_wr,
  input  logic        m1_rd,
  output logic [31:0] m1_rd_data,
  output logic        m1_rd_valid,
  output logic        m1_busy,
  output logic        m1_ovf,
  output logic [31:0] s_addr,
  output logic [31:0] s_wr_data,
  output logic        s_wr,
  output logic        s_rd,
  input  logic [31:0] s_rd_data
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam bit          LAT_ZERO = (RD_LAT == 0);
  localparam logic [CW-1:0] CNT_INIT = CW'((RD_LAT == 0) ? 0 : RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_e;

  state_e state_q, state_d;

  logic [DW-1:0] m_addr [2];
  logic [DW-1:0] m_data [2];
  logic [1:0]    m_wr, m_rd;

  logic [1:0]    buf_full_q, buf_full_d;
  logic [1:0]    buf_wr_q, buf_wr_d;
  logic [DW-1:0] buf_addr_q [2];
  logic [DW-1:0] buf_addr_d [2];
  logic [DW-1:0] buf_data_q [2];
  logic [DW-1:0] buf_data_d [2];

  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          acc_wr_q, acc_wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0] s_wr_data_q, s_wr_data_d;
  logic          s_wr_q, s_wr_d;
  logic          s_rd_q, s_rd_d;
  logic [DW-1:0] rd_data_q [2];
  logic [DW-1:0] rd_data_d [2];
  logic [1:0]    rd_valid_q, rd_valid_d;
  logic [1:0]    busy_q, busy_d;
  logic [1:0]    ovf_q, ovf_d;

  logic          grant_c;
  logic          win_c;
  logic          rd_done_c;

  assign m_addr[0] = m0_addr;
  assign m_addr[1] = m1_addr;
  assign m_data[0] = m0_wr_data;
  assign m_data[1] = m1_wr_data;
  assign m_wr      = {m1_wr, m0_wr};
  assign m_rd      = {m1_rd, m0_rd};

  // Grant only from IDLE. On a tie the master not granted last wins.
  assign grant_c   = (state_q == IDLE) && (|buf_full_q);
  assign win_c     = (&buf_full_q) ? ~last_q : ~buf_full_q[0];
  assign rd_done_c = ((state_q == ISSUE) && !acc_wr_q && LAT_ZERO) ||
                     ((state_q == RD_WAIT) && (cnt_q == '0));

  // State register
  always_ff @(posedge up_clk or negedge up_rst_n) begin
    if (!up_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_c) state_d = ISSUE;
      ISSUE:   state_d = (acc_wr_q || LAT_ZERO) ? IDLE : RD_WAIT;
      RD_WAIT: if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    buf_full_d  = buf_full_q;
    buf_wr_d    = buf_wr_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    acc_wr_d    = acc_wr_q;
    cnt_d       = cnt_q;
    s_addr_d    = s_addr_q;
    s_wr_data_d = s_wr_data_q;
    s_wr_d      = 1'b0;
    s_rd_d      = 1'b0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 2'b00;
    ovf_d       = ovf_q;
    busy_d      = 2'b00;

    if (grant_c) begin
      gnt_d               = win_c;
      last_d              = win_c;
      acc_wr_d            = buf_wr_q[win_c];
      s_addr_d            = buf_addr_q[win_c];
      s_wr_data_d         = buf_data_q[win_c];
      s_wr_d              = buf_wr_q[win_c];
      s_rd_d              = ~buf_wr_q[win_c];
      buf_full_d[win_c]   = 1'b0;
    end

    // The counter holds the number of RD_WAIT cycles still to run after this one
    if ((state_q == ISSUE) && !acc_wr_q && !LAT_ZERO) cnt_d = CNT_INIT;
    else if ((state_q == RD_WAIT) && (cnt_q != '0))   cnt_d = cnt_q - CW'(1);

    if (rd_done_c) begin
      rd_data_d[gnt_q]  = s_rd_data;
      rd_valid_d[gnt_q] = 1'b1;
    end

    // Capture runs after the grant clear, so a new strobe on the grant edge is kept
    for (int n = 0; n < 2; n++) begin
      if (m_wr[n] && m_rd[n]) ovf_d[n] = 1'b1;
      if (m_wr[n] || m_rd[n]) begin
        if (!buf_full_q[n] || (grant_c && (win_c == 1'(n)))) begin
          buf_full_d[n] = 1'b1;
          buf_wr_d[n]   = m_wr[n];
          buf_addr_d[n] = m_addr[n];
          buf_data_d[n] = m_data[n];
        end else begin
          ovf_d[n] = 1'b1;
        end
      end
      busy_d[n] = buf_full_d[n] || ((state_d != IDLE) && (gnt_d == 1'(n)));
    end
  end

  // Datapath and output registers
  always_ff @(posedge up_clk or negedge up_rst_n) begin
    if (!up_rst_n) begin
      buf_full_q  <= '0;
      buf_wr_q    <= '0;
      buf_addr_q  <= '{default: '0};
      buf_data_q  <= '{default: '0};
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      acc_wr_q    <= 1'b0;
      cnt_q       <= '0;
      s_addr_q    <= '0;
      s_wr_data_q <= '0;
      s_wr_q      <= 1'b0;
      s_rd_q      <= 1'b0;
      rd_data_q   <= '{default: '0};
      rd_valid_q  <= '0;
      busy_q      <= '0;
      ovf_q       <= '0;
    end else begin
      buf_full_q  <= buf_full_d;
      buf_wr_q    <= buf_wr_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      acc_wr_q    <= acc_wr_d;
      cnt_q       <= cnt_d;
      s_addr_q    <= s_addr_d;
      s_wr_data_q <= s_wr_data_d;
      s_wr_q      <= s_wr_d;
      s_rd_q      <= s_rd_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign s_addr      = s_addr_q;
  assign s_wr_data   = s_wr_data_q;
  assign s_wr        = s_wr_q;
  assign s_rd        = s_rd_q;
  assign m0_rd_data  = rd_data_q[0];
  assign m1_rd_data  = rd_data_q[1];
  assign m0_rd_valid = rd_valid_q[0];
  assign m1_rd_valid = rd_valid_q[1];
  assign m0_busy     = busy_q[0];
  assign m1_busy     = busy_q[1];
  assign m0_ovf      = ovf_q[0];
  assign m1_ovf      = ovf_q[1];

endmodule

// File: tb/tb_up_bus_arbiter.sv
// Testbench for up_bus_arbiter. Two instances share one set of stimulus:
// instance 0 uses RD_LAT=2 and instance 1 uses RD_LAT=0. A transaction-level
// reference model of each instance predicts every output after each edge.
module tb_up_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][31:0] m_addr, m_data;
  logic [1:0]       m_wr, m_rd;
  logic [31:0]      s_rd_data;

  logic [1:0][1:0][31:0] rdd_o;
  logic [1:0][1:0]       rdv_o, busy_o, ovf_o;
  logic [1:0][31:0]      saddr_o, sdata_o;
  logic [1:0]            swr_o, srd_o;

  int n_assert = 0;
  int n_fail   = 0;

  up_bus_arbiter #(.RD_LAT(2)) dut_a (
    .up_clk(clk), .up_rst_n(rst_n),
    .m0_addr(m_addr[0]), .m0_wr_data(m_data[0]), .m0_wr(m_wr[0]), .m0_rd(m_rd[0]),
    .m0_rd_data(rdd_o[0][0]), .m0_rd_valid(rdv_o[0][0]), .m0_busy(busy_o[0][0]), .m0_ovf(ovf_o[0][0]),
    .m1_addr(m_addr[1]), .m1_wr_data(m_data[1]), .m1_wr(m_wr[1]), .m1_rd(m_rd[1]),
    .m1_rd_data(rdd_o[0][1]), .m1_rd_valid(rdv_o[0][1]), .m1_busy(busy_o[0][1]), .m1_ovf(ovf_o[0][1]),
    .s_addr(saddr_o[0]), .s_wr_data(sdata_o[0]), .s_wr(swr_o[0]), .s_rd(srd_o[0]),
    .s_rd_data(s_rd_data)
  );

  up_bus_arbiter #(.RD_LAT(0)) dut_b (
    .up_clk(clk), .up_rst_n(rst_n),
    .m0_addr(m_addr[0]), .m0_wr_data(m_data[0]), .m0_wr(m_wr[0]), .m0_rd(m_rd[0]),
    .m0_rd_data(rdd_o[1][0]), .m0_rd_valid(rdv_o[1][0]), .m0_busy(busy_o[1][0]), .m0_ovf(ovf_o[1][0]),
    .m1_addr(m_addr[1]), .m1_wr_data(m_data[1]), .m1_wr(m_wr[1]), .m1_rd(m_rd[1]),
    .m1_rd_data(rdd_o[1][1]), .m1_rd_valid(rdv_o[1][1]), .m1_busy(busy_o[1][1]), .m1_ovf(ovf_o[1][1]),
    .s_addr(saddr_o[1]), .s_wr_data(sdata_o[1]), .s_wr(swr_o[1]), .s_rd(srd_o[1]),
    .s_rd_data(s_rd_data)
  );

  // Reference model: pending requests, one in-flight access with the number
  // of edges left until it finishes, and the expected outputs.
  int          lat [2] = '{2, 0};
  bit          pv [2][2];
  bit          pw [2][2];
  logic [31:0] pa [2][2];
  logic [31:0] pd [2][2];
  bit          fly [2];
  bit          fwr [2];
  int          fm [2];
  int          left [2];
  int          lastg [2];
  logic [31:0] e_saddr [2];
  logic [31:0] e_sdata [2];
  bit          e_swr [2];
  bit          e_srd [2];
  logic [31:0] e_rdd [2][2];
  bit          e_rdv [2][2];
  bit          e_busy [2][2];
  bit          e_ovf [2][2];

  task automatic mdl_reset();
    for (int k = 0; k < 2; k++) begin
      fly[k] = 0; fwr[k] = 0; fm[k] = 0; left[k] = 0; lastg[k] = 1;
      e_saddr[k] = '0; e_sdata[k] = '0; e_swr[k] = 0; e_srd[k] = 0;
      for (int n = 0; n < 2; n++) begin
        pv[k][n] = 0; pw[k][n] = 0; pa[k][n] = '0; pd[k][n] = '0;
        e_rdd[k][n] = '0; e_rdv[k][n] = 0; e_busy[k][n] = 0; e_ovf[k][n] = 0;
      end
    end
  endtask

  task automatic mdl_edge();
    for (int k = 0; k < 2; k++) begin
      bit idle;
      int granted;
      idle    = !fly[k];
      granted = -1;
      e_swr[k] = 0;
      e_srd[k] = 0;
      for (int n = 0; n < 2; n++) e_rdv[k][n] = 0;
      if (fly[k]) begin
        if (left[k] == 1) begin
          if (!fwr[k]) begin
            e_rdd[k][fm[k]] = s_rd_data;
            e_rdv[k][fm[k]] = 1;
          end
          fly[k] = 0;
        end else begin
          left[k]--;
        end
      end
      if (idle && (pv[k][0] || pv[k][1])) begin
        int w;
        w = (pv[k][0] && pv[k][1]) ? 1 - lastg[k] : (pv[k][0] ? 0 : 1);
        lastg[k]   = w;
        granted    = w;
        fly[k]     = 1;
        fm[k]      = w;
        fwr[k]     = pw[k][w];
        left[k]    = pw[k][w] ? 1 : lat[k] + 1;
        e_saddr[k] = pa[k][w];
        e_sdata[k] = pd[k][w];
        e_swr[k]   = pw[k][w];
        e_srd[k]   = !pw[k][w];
        pv[k][w]   = 0;
      end
      for (int n = 0; n < 2; n++) begin
        if (m_wr[n] && m_rd[n]) e_ovf[k][n] = 1;
        if (m_wr[n] || m_rd[n]) begin
          if (!pv[k][n] || granted == n) begin
            pv[k][n] = 1; pw[k][n] = m_wr[n]; pa[k][n] = m_addr[n]; pd[k][n] = m_data[n];
          end else begin
            e_ovf[k][n] = 1;
          end
        end
        e_busy[k][n] = pv[k][n] || (fly[k] && fm[k] == n);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("L%0d s_addr", lat[k]), saddr_o[k], e_saddr[k]);
      chk($sformatf("L%0d s_wr_data", lat[k]), sdata_o[k], e_sdata[k]);
      chk($sformatf("L%0d s_wr", lat[k]), 32'(swr_o[k]), 32'(e_swr[k]));
      chk($sformatf("L%0d s_rd", lat[k]), 32'(srd_o[k]), 32'(e_srd[k]));
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("L%0d m%0d_rd_data", lat[k], n), rdd_o[k][n], e_rdd[k][n]);
        chk($sformatf("L%0d m%0d_rd_valid", lat[k], n), 32'(rdv_o[k][n]), 32'(e_rdv[k][n]));
        chk($sformatf("L%0d m%0d_busy", lat[k], n), 32'(busy_o[k][n]), 32'(e_busy[k][n]));
        chk($sformatf("L%0d m%0d_ovf", lat[k], n), 32'(ovf_o[k][n]), 32'(e_ovf[k][n]));
      end
    end
  endtask

  // One clock edge: model follows unless reset is held, outputs checked 1 ns later
  task automatic step();
    @(posedge clk);
    if (rst_n) mdl_edge();
    #1;
    check_all();
  endtask

  task automatic idle_in();
    m_wr = '0; m_rd = '0;
  endtask

  task automatic strobe(input int n, input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    m_wr[n] = wr; m_rd[n] = rd; m_addr[n] = a; m_data[n] = d;
  endtask

  // Assert reset between edges, check the asynchronous clear, release after an edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    mdl_reset();
    #1 check_all();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    m_addr = '0; m_data = '0; m_wr = '0; m_rd = '0; s_rd_data = '0;
    mdl_reset();
    #2 check_all();
    step();
    rst_n = 1'b1;

    // m0 write: strobe at E0, s_wr during E1-E2, idle after E2
    strobe(0, 1, 0, 32'h10, 32'hA5A5A5A5);
    step();
    idle_in();
    step();
    chk("d_wr s_wr", 32'(swr_o[0]), 32'd1);
    chk("d_wr s_addr", saddr_o[0], 32'h10);
    chk("d_wr s_wr_data", sdata_o[0], 32'hA5A5A5A5);
    step();
    chk("d_wr s_wr low", 32'(swr_o[0]), 32'd0);
    chk("d_wr m0_busy low", 32'(busy_o[0][0]), 32'd0);
    step();

    // m1 read with the slave returning a fixed word
    s_rd_data = 32'h12345678;
    strobe(1, 0, 1, 32'h20, 32'h0);
    step();
    idle_in();
    step();
    chk("d_rd s_rd", 32'(srd_o[0]), 32'd1);
    step();
    chk("d_rd0 m1_rd_valid", 32'(rdv_o[1][1]), 32'd1);
    chk("d_rd0 m1_rd_data", rdd_o[1][1], 32'h12345678);
    step();
    step();
    chk("d_rd2 m1_rd_valid", 32'(rdv_o[0][1]), 32'd1);
    chk("d_rd2 m1_rd_data", rdd_o[0][1], 32'h12345678);
    chk("d_rd2 m0_rd_valid", 32'(rdv_o[0][0]), 32'd0);
    for (int i = 0; i < 3; i++) step();

    // Tie after reset goes to m0; after an m0-only grant the tie goes to m1
    do_reset();
    strobe(0, 1, 0, 32'h100, 32'hAAAA0000);
    strobe(1, 1, 0, 32'h200, 32'hBBBB0000);
    step();
    idle_in();
    step();
    chk("tie1 s_addr", saddr_o[0], 32'h100);
    for (int i = 0; i < 3; i++) step();
    strobe(0, 1, 0, 32'h104, 32'h1);
    step();
    idle_in();
    for (int i = 0; i < 3; i++) step();
    strobe(0, 1, 0, 32'h108, 32'h2);
    strobe(1, 1, 0, 32'h208, 32'h3);
    step();
    idle_in();
    step();
    chk("tie2 s_addr", saddr_o[0], 32'h208);
    for (int i = 0; i < 4; i++) step();

    // m1 read in flight; m0 strobe buffered, second m0 strobe dropped
    do_reset();
    strobe(1, 0, 1, 32'h300, 32'h0);
    step();
    idle_in();
    strobe(0, 1, 0, 32'h400, 32'hC0C0C0C0);
    step();
    strobe(0, 1, 0, 32'h404, 32'hDEADBEEF);
    step();
    idle_in();
    chk("drop m0_ovf", 32'(ovf_o[0][0]), 32'd1);
    for (int i = 0; i < 3; i++) step();
    chk("drop s_addr", saddr_o[0], 32'h400);
    chk("drop s_wr_data", sdata_o[0], 32'hC0C0C0C0);
    for (int i = 0; i < 3; i++) step();

    // Reset while instance 0 is in RD_WAIT, then a normal m0 read
    strobe(0, 0, 1, 32'h500, 32'h0);
    step();
    idle_in();
    step();
    step();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    s_rd_data = 32'hCAFEF00D;
    strobe(0, 0, 1, 32'h504, 32'h0);
    step();
    idle_in();
    for (int i = 0; i < 5; i++) step();
    chk("rst rd m0_rd_data", rdd_o[0][0], 32'hCAFEF00D);

    // Both strobes high together count as a write and flag overflow
    strobe(1, 1, 1, 32'h600, 32'h77);
    step();
    idle_in();
    for (int i = 0; i < 3; i++) step();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      s_rd_data = $urandom;
      for (int n = 0; n < 2; n++) begin
        m_wr[n]   = ($urandom_range(0, 5) == 0);
        m_rd[n]   = ($urandom_range(0, 5) == 0);
        m_addr[n] = $urandom;
        m_data[n] = $urandom;
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
